// File: rtl/axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_arbiter
//
// Shares one AXI4-Lite slave port between two AXI4-Lite masters. Only one
// transaction (read or write) is in flight at a time. The masters are served
// round-robin. Within one master, a pending write goes ahead of a pending read.
//
// Ports (per-master vectors pack master 1 above master 0):
//   aclk, areset                  clock, asynchronous active-high reset
//   m_aw*/m_w*/m_b*/m_ar*/m_r*    master-side AXI4-Lite channels
//   s_aw*/s_w*/s_b*/s_ar*/s_r*    slave-side AXI4-Lite channels
//   grant                         one-hot owner of the slave port, 0 when idle
//   busy                          high while a transaction owns the slave port
// -----------------------------------------------------------------------------
module axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic [2*ADDR_WIDTH-1:0]       m_awaddr,
    input  logic [1:0]                    m_awvalid,
    output logic [1:0]                    m_awready,
    input  logic [2*DATA_WIDTH-1:0]       m_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0]   m_wstrb,
    input  logic [1:0]                    m_wvalid,
    output logic [1:0]                    m_wready,
    output logic [3:0]                    m_bresp,
    output logic [1:0]                    m_bvalid,
    input  logic [1:0]                    m_bready,
    input  logic [2*ADDR_WIDTH-1:0]       m_araddr,
    input  logic [1:0]                    m_arvalid,
    output logic [1:0]                    m_arready,
    output logic [2*DATA_WIDTH-1:0]       m_rdata,
    output logic [3:0]                    m_rresp,
    output logic [1:0]                    m_rvalid,
    input  logic [1:0]                    m_rready,

    output logic [ADDR_WIDTH-1:0]         s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_WIDTH-1:0]         s_wdata,
    output logic [DATA_WIDTH/8-1:0]       s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    output logic [ADDR_WIDTH-1:0]         s_araddr,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rvalid,
    output logic                          s_rready,

    output logic [1:0]                    grant,
    output logic                          busy
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    state_t state_q, state_d;
    logic   g_q, g_d;
    logic   prio_q, prio_d;
    logic   awDone_q, awDone_d;
    logic   wDone_q, wDone_d;

    logic [1:0] wreq;
    logic [1:0] req;
    logic       reqSel;
    logic       awNow;
    logic       wNow;

    logic                    selAwready;
    logic                    selWready;
    logic                    selBvalid;
    logic [1:0]              selBresp;
    logic                    selArready;
    logic                    selRvalid;
    logic [DATA_WIDTH-1:0]   selRdata;
    logic [1:0]              selRresp;

    // A write only counts as a request once both its address and its data
    // are offered, so a master is never parked in WADDR waiting on itself.
    assign wreq = m_awvalid & m_wvalid;
    assign req  = wreq | m_arvalid;

    // State register. Reset abandons any in-flight transaction immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            g_q      <= 1'b0;
            prio_q   <= 1'b0;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            prio_q   <= prio_d;
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
        end
    end

    // Next-state logic: arbitration in IDLE, then walk the channel phases of
    // the granted transaction. Priority flips to the other master only when a
    // transaction actually completes.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        prio_d   = prio_q;
        awDone_d = awDone_q;
        wDone_d  = wDone_q;
        reqSel   = 1'b0;
        awNow    = awDone_q | (s_awvalid & s_awready);
        wNow     = wDone_q | (s_wvalid & s_wready);

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    reqSel  = (req == 2'b11) ? prio_q : req[1];
                    g_d     = reqSel;
                    state_d = wreq[reqSel] ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // AW and W may complete in either order or together; the done
                // flags keep each channel from being presented twice.
                if (awNow && wNow) begin
                    state_d  = WRESP;
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                end else begin
                    awDone_d = awNow;
                    wDone_d  = wNow;
                end
            end
            WRESP: begin
                if (s_bvalid && s_bready) begin
                    state_d = IDLE;
                    prio_d  = ~g_q;
                end
            end
            RADDR: begin
                if (s_arvalid && s_arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (s_rvalid && s_rready) begin
                    state_d = IDLE;
                    prio_d  = ~g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side outputs and the granted master's return path. Only the
    // channels of the current phase are opened, so a stray B or R from the
    // slave outside its phase never reaches a master.
    always_comb begin
        busy       = (state_q != IDLE);
        grant      = busy ? (g_q ? 2'b10 : 2'b01) : 2'b00;

        s_awaddr   = '0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_araddr   = '0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;

        selAwready = 1'b0;
        selWready  = 1'b0;
        selBvalid  = 1'b0;
        selBresp   = 2'b00;
        selArready = 1'b0;
        selRvalid  = 1'b0;
        selRdata   = '0;
        selRresp   = 2'b00;

        if (busy) begin
            s_awaddr = g_q ? m_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_awaddr[ADDR_WIDTH-1:0];
            s_wdata  = g_q ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
            s_wstrb  = g_q ? m_wstrb[2*(DATA_WIDTH/8)-1:DATA_WIDTH/8] : m_wstrb[DATA_WIDTH/8-1:0];
            s_araddr = g_q ? m_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_araddr[ADDR_WIDTH-1:0];
        end

        case (state_q)
            WADDR: begin
                s_awvalid  = m_awvalid[g_q] & ~awDone_q;
                s_wvalid   = m_wvalid[g_q] & ~wDone_q;
                selAwready = s_awready & ~awDone_q;
                selWready  = s_wready & ~wDone_q;
            end
            WRESP: begin
                s_bready  = m_bready[g_q];
                selBvalid = s_bvalid;
                selBresp  = s_bresp;
            end
            RADDR: begin
                s_arvalid  = m_arvalid[g_q];
                selArready = s_arready;
            end
            RDATA: begin
                s_rready  = m_rready[g_q];
                selRvalid = s_rvalid;
                selRdata  = s_rdata;
                selRresp  = s_rresp;
            end
            default: ;
        endcase
    end

    // Steer the return path to the granted master; the other master sees
    // zeros on every ready, valid, response and data lane.
    always_comb begin
        m_awready = {selAwready & g_q, selAwready & ~g_q};
        m_wready  = {selWready & g_q, selWready & ~g_q};
        m_bvalid  = {selBvalid & g_q, selBvalid & ~g_q};
        m_arready = {selArready & g_q, selArready & ~g_q};
        m_rvalid  = {selRvalid & g_q, selRvalid & ~g_q};
        m_bresp   = g_q ? {selBresp, 2'b00} : {2'b00, selBresp};
        m_rresp   = g_q ? {selRresp, 2'b00} : {2'b00, selRresp};
        m_rdata   = g_q ? {selRdata, {DATA_WIDTH{1'b0}}} : {{DATA_WIDTH{1'b0}}, selRdata};
    end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master to one-slave AXI4-Lite arbiter. It shares a single slave port between two AXI4-Lite masters, with at most one transaction (read or write) in flight at a time. Masters are granted round-robin; within one master, a pending write has priority over a pending read. It sits between the master agents and the slave model in the interconnect, and uses the same channel signal set as the existing master/slave interface, flattened per master.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; STRB width is DATA_WIDTH/8

Ports (index i = master 0/1; each per-master vector packs master 1 above master 0):
- aclk  input  1  clock; all logic on rising edge
- areset  input  1  reset. One clock; reset is asynchronous and active-high.
- m_awaddr, m_araddr  input  2*ADDR_WIDTH  master addresses
- m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready  input  2  master valids/readies
- m_wdata  input  2*DATA_WIDTH  write data
- m_wstrb  input  2*DATA_WIDTH/8  write strobes
- m_awready, m_wready, m_arready, m_bvalid, m_rvalid  output  2  returned readies/valids
- m_bresp, m_rresp  output  2*2  responses
- m_rdata  output  2*DATA_WIDTH  read data
- s_awaddr, s_araddr  output  ADDR_WIDTH  slave addresses
- s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready  output  1  slave valids/readies
- s_wdata  output  DATA_WIDTH; s_wstrb  output  DATA_WIDTH/8
- s_awready, s_wready, s_arready, s_bvalid, s_rvalid  input  1  slave readies/valids
- s_bresp, s_rresp  input  2; s_rdata  input  DATA_WIDTH
- grant  output  2  one-hot owner of the slave port, 0 when IDLE
- busy  output  1  high when not in IDLE

## Operation
- Request definitions:
  - Write request wreq[i] = m_awvalid[i] & m_wvalid[i].
  - Read request rreq[i] = m_arvalid[i].
  - Request req[i] = wreq[i] | rreq[i].
- Registered state:
  - FSM: IDLE, WADDR, WRESP, RADDR, RDATA.
  - Grant register g.
  - Priority pointer prio (master favoured on a tie).
  - Flags aw_done and w_done.
- IDLE:
  - If only one req[i] is high, grant i.
  - If both are high, grant prio.
  - For the granted master: go to WADDR if wreq, otherwise RADDR.
  - With no request, stay in IDLE.
- WADDR:
  - s_aw* and s_w* are driven from master g.
  - s_awvalid = m_awvalid[g] & !aw_done; s_wvalid = m_wvalid[g] & !w_done.
  - m_awready[g] = s_awready & !aw_done; m_wready[g] likewise.
  - aw_done sets on the AW handshake and w_done on the W handshake; the two may occur in the same cycle or in either order.
  - When both flags are (or become) set, go to WRESP and clear both flags.
- WRESP:
  - s_bready = m_bready[g]; m_bvalid[g] = s_bvalid; m_bresp[g] = s_bresp.
  - On the B handshake, go to IDLE and set prio = ~g.
- RADDR: forward AR from g. On the AR handshake, go to RDATA.
- RDATA:
  - Forward R to g.
  - On the R handshake, go to IDLE and set prio = ~g.
- Non-granted master: all its readies and valids are 0. m_rdata and m_bresp for it are 0.
- Slave outputs:
  - In IDLE all s_* valids and readies are 0.
  - Address and data buses are muxed from g at all times; their values are don't-care when the matching valid is low.
- No combinational path from m_*valid to s_*valid other than through the registered g and state.

## Timing
- Reset state:
  - state = IDLE, g = 0, prio = 0, aw_done = w_done = 0.
  - All valid/ready outputs 0, grant = 0, busy = 0, buses 0.
- Arbitration latency:
  - A request sampled in IDLE at edge N gives grant and busy high after N.
  - s_awvalid/s_arvalid assert in the cycle following edge N (one cycle after the request is first visible).
- Handshake rules:
  - A handshake is valid & ready high at a rising edge.
  - Masters keep their valid and payload stable until ready.
  - The arbiter never drops s_*valid before the handshake.
- End of transaction:
  - The cycle after the last handshake (B or R) is IDLE.
  - The earliest next grant is registered at the end of that IDLE cycle, giving a minimum 1 idle cycle between transactions.
- Back-to-back fairness:
  - Both masters continuously requesting alternate 0,1,0,1 starting from prio.
  - A master's write and read pending together: write first, then read, subject to round-robin with the other master.
- Boundary conditions:
  - A request withdrawn in IDLE before the grant edge is ignored.
  - A slave B/R response in IDLE/WADDR/RADDR is not forwarded (protocol error; no state change).
- Reset mid-transaction: asynchronously return to the reset state; the in-flight transaction is abandoned and outputs drop the same cycle.

## Test plan
- Single write, master 0: addr 0x10, data 0xDEADBEEF, strb 0xF; slave ready. -> s_awaddr 0x10 and s_wdata 0xDEADBEEF the cycle after the request; m_bvalid[0] mirrors s_bvalid with bresp 0; grant returns to 0.
- Simultaneous reads, both masters, after reset (prio 0): M0 0x20, M1 0x24. -> M0 served first, then M1; m_rdata routed only to the requester; m_rvalid of the other master stays 0 throughout.
- Both masters requesting continuously for 6 transactions. -> grant sequence 01,10,01,10,01,10 with a one-cycle IDLE gap between each.
- W handshake 3 cycles before AW (s_awready delayed). -> s_wvalid drops after the W handshake, WADDR is held until AW, exactly one AW and one W reach the slave.
- Master 1 with a write and a read pending together. -> the write completes (B) before AR is forwarded.
- areset asserted during RDATA while s_rvalid=0. -> all outputs 0 immediately, and after release a fresh request from master 1 is granted with prio 0 behaviour.
